// File: rtl/mult64_accumulate_stage.sv
`timescale 1ns/1ps
// mult64_accumulate_stage
// Accumulates the unsigned 64-bit products of the approximate multiplier into
// an ACC_W-bit saturating sum. A result closes on in_last or after MAX_TERMS
// terms, is then held on out_* until the consumer takes it, and the stage
// resumes accepting products on the cycle after the drain.
module mult64_accumulate_stage #(
    parameter int unsigned ACC_W     = 72,
    parameter int unsigned MAX_TERMS = 256,
    parameter int unsigned CNT_W     = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_product,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overflow
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_count;
    logic               r_ovf;
    logic [ACC_W-1:0]   w_acc_next;
    logic [CNT_W-1:0]   w_count_next;
    logic               w_ovf_next;

    logic [ACC_W-1:0]   r_out_sum;
    logic [CNT_W-1:0]   r_out_count;
    logic               r_out_ovf;

    logic               w_accept;
    logic               w_close;
    logic               w_load_out;
    logic [ACC_W:0]     w_sum_wide;
    logic [ACC_W-1:0]   w_acc_sum;
    logic               w_ovf_sum;
    logic [CNT_W-1:0]   w_count_inc;

    // clear blocks acceptance in the same cycle so an aborted result never
    // swallows a product.
    assign in_ready  = (r_state == ACCUM) && !clear;
    assign out_valid = (r_state == HOLD);
    assign w_accept  = in_valid && in_ready;

    // One extra bit catches the carry out; a carry pins the sum at all-ones,
    // and an already saturated sum stays there because any nonzero add carries.
    assign w_sum_wide  = {1'b0, r_acc} + (ACC_W + 1)'(in_product);
    assign w_acc_sum   = w_sum_wide[ACC_W] ? '1 : w_sum_wide[ACC_W-1:0];
    assign w_ovf_sum   = r_ovf | w_sum_wide[ACC_W];
    assign w_count_inc = r_count + CNT_W'(1);
    assign w_close     = in_last || (w_count_inc == CNT_W'(MAX_TERMS));

    assign out_sum      = r_out_sum;
    assign out_count    = r_out_count;
    assign out_overflow = r_out_ovf;

    // Next-state and next-accumulator selection; clear overrides everything.
    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_count_next = r_count;
        w_ovf_next   = r_ovf;
        w_load_out   = 1'b0;
        if (clear) begin
            w_state_next = ACCUM;
            w_acc_next   = '0;
            w_count_next = '0;
            w_ovf_next   = 1'b0;
        end else begin
            unique case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        w_acc_next   = w_acc_sum;
                        w_count_next = w_count_inc;
                        w_ovf_next   = w_ovf_sum;
                        if (w_close) begin
                            w_load_out   = 1'b1;
                            w_state_next = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        w_state_next = ACCUM;
                        w_acc_next   = '0;
                        w_count_next = '0;
                        w_ovf_next   = 1'b0;
                    end
                end
                default: begin
                    w_state_next = ACCUM;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Running accumulator, term count and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_acc   <= w_acc_next;
            r_count <= w_count_next;
            r_ovf   <= w_ovf_next;
        end
    end

    // Result registers: loaded on the closing accept, held through HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else if (clear) begin
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_load_out) begin
            r_out_sum   <= w_acc_sum;
            r_out_count <= w_count_inc;
            r_out_ovf   <= w_ovf_sum;
        end
    end

endmodule
